// File: rtl/svc_sram_burst_arb.sv
// -----------------------------------------------------------------------------
// svc_sram_burst_arb
//   Round-robin arbiter sharing one striped-SRAM burst port (cmd / wr / rd
//   channels) between NUM_M requesters. A grant covers a whole burst: the
//   command handshake followed by all len+1 write beats or all len+1 read beats.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   m_cmd_valid/ready/addr/len/wr  per-requester burst command
//   m_wr_valid/data/ready          per-requester write beats
//   m_rd_valid                     per-requester read beat strobe (grant only)
//   m_rd_data                      read beat data, broadcast to all requesters
//   s_cmd_*                        command forwarded to the SRAM controller
//   s_wr_valid/data/ready          write beats forwarded to the controller
//   s_rd_valid/data                read beats from the controller (no backpressure)
//
// Also contains svc_sram_burst_arb_chk, the protocol checker bound inside the top.
// -----------------------------------------------------------------------------

module svc_sram_burst_arb_chk #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int LEN_WIDTH  = 8
) (
    input logic                  clk,
    input logic                  rst,
    input logic [NUM_M-1:0]      m_cmd_ready,
    input logic [NUM_M-1:0]      m_wr_ready,
    input logic [NUM_M-1:0]      m_rd_valid,
    input logic                  s_cmd_valid,
    input logic                  s_cmd_ready,
    input logic [ADDR_WIDTH-1:0] s_cmd_addr,
    input logic [LEN_WIDTH-1:0]  s_cmd_len,
    input logic                  s_cmd_wr,
    input logic                  s_wr_valid
);

    // Only the granted requester may ever see a handshake or a read strobe.
    a_cmd_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(m_cmd_ready));
    a_wr_ready_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(m_wr_ready));
    a_rd_valid_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(m_rd_valid));

    // Write beats are only forwarded while a write burst owns the port.
    a_no_wr_on_read: assert property (@(posedge clk) disable iff (rst) s_wr_valid |-> s_cmd_wr);

    // A stalled command must hold its payload until accepted.
    a_cmd_stable: assert property (@(posedge clk) disable iff (rst)
        (s_cmd_valid && !s_cmd_ready) |=>
        (s_cmd_valid && $stable(s_cmd_addr) && $stable(s_cmd_len) && $stable(s_cmd_wr)));

endmodule

module svc_sram_burst_arb #(
    parameter int NUM_M      = 2,
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 16,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_M-1:0]                     m_cmd_valid,
    output logic [NUM_M-1:0]                     m_cmd_ready,
    input  logic [NUM_M-1:0][ADDR_WIDTH-1:0]     m_cmd_addr,
    input  logic [NUM_M-1:0][LEN_WIDTH-1:0]      m_cmd_len,
    input  logic [NUM_M-1:0]                     m_cmd_wr,
    input  logic [NUM_M-1:0]                     m_wr_valid,
    input  logic [NUM_M-1:0][DATA_WIDTH-1:0]     m_wr_data,
    output logic [NUM_M-1:0]                     m_wr_ready,
    output logic [NUM_M-1:0]                     m_rd_valid,
    output logic [DATA_WIDTH-1:0]                m_rd_data,
    output logic                                 s_cmd_valid,
    input  logic                                 s_cmd_ready,
    output logic [ADDR_WIDTH-1:0]                s_cmd_addr,
    output logic [LEN_WIDTH-1:0]                 s_cmd_len,
    output logic                                 s_cmd_wr,
    output logic                                 s_wr_valid,
    output logic [DATA_WIDTH-1:0]                s_wr_data,
    input  logic                                 s_wr_ready,
    input  logic                                 s_rd_valid,
    input  logic [DATA_WIDTH-1:0]                s_rd_data
);

    localparam int GW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam logic [GW-1:0] LAST_IDX = GW'(NUM_M - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;

    logic [1:0]            state_r;
    logic [GW-1:0]         rr_ptr_r;
    logic [GW-1:0]         grant_idx_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic [LEN_WIDTH-1:0]  len_r;
    logic                  wr_r;
    logic [LEN_WIDTH-1:0]  beat_cnt_r;

    logic                  pick_found_s;
    logic [GW-1:0]         pick_idx_s;
    logic                  gnt_wr_valid_s;
    logic                  beat_hs_s;
    logic                  last_beat_s;
    logic [GW-1:0]         rr_next_s;

    // Round-robin search: first valid requester at or after rr_ptr, wrapping.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = {GW{1'b0}};
        for (int i = 0; i < NUM_M; i++) begin
            if (!pick_found_s && m_cmd_valid[(int'(rr_ptr_r) + i) % NUM_M]) begin
                pick_found_s = 1'b1;
                pick_idx_s   = GW'((int'(rr_ptr_r) + i) % NUM_M);
            end else begin
                pick_idx_s   = pick_idx_s;
            end
        end
    end

    // Beat handshake and end-of-burst detection. Comparing the pre-increment
    // count against len means len = all-ones never needs a wider counter.
    always_comb begin
        gnt_wr_valid_s = m_wr_valid[grant_idx_r];
        last_beat_s    = (beat_cnt_r == len_r);
        rr_next_s      = (grant_idx_r == LAST_IDX) ? {GW{1'b0}} : (grant_idx_r + {{(GW-1){1'b0}}, 1'b1});
        if (state_r == ST_XFER) begin
            beat_hs_s = wr_r ? (gnt_wr_valid_s && s_wr_ready) : s_rd_valid;
        end else begin
            beat_hs_s = 1'b0;
        end
    end

    // Arbitration FSM and burst bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= {GW{1'b0}};
            grant_idx_r <= {GW{1'b0}};
            addr_r      <= {ADDR_WIDTH{1'b0}};
            len_r       <= {LEN_WIDTH{1'b0}};
            wr_r        <= 1'b0;
            beat_cnt_r  <= {LEN_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_found_s) begin
                        grant_idx_r <= pick_idx_s;
                        addr_r      <= m_cmd_addr[pick_idx_s];
                        len_r       <= m_cmd_len[pick_idx_s];
                        wr_r        <= m_cmd_wr[pick_idx_s];
                        state_r     <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (s_cmd_ready) begin
                        beat_cnt_r <= {LEN_WIDTH{1'b0}};
                        rr_ptr_r   <= rr_next_s;
                        state_r    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (beat_hs_s) begin
                        if (last_beat_s) begin
                            state_r <= ST_IDLE;
                        end else begin
                            beat_cnt_r <= beat_cnt_r + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    // Channel steering: only the granted requester is connected, and only in
    // the phase of the burst that uses that channel.
    always_comb begin
        m_cmd_ready = {NUM_M{1'b0}};
        m_wr_ready  = {NUM_M{1'b0}};
        m_rd_valid  = {NUM_M{1'b0}};
        s_cmd_valid = 1'b0;
        s_wr_valid  = 1'b0;
        s_wr_data   = {DATA_WIDTH{1'b0}};
        case (state_r)
            ST_CMD: begin
                s_cmd_valid              = 1'b1;
                m_cmd_ready[grant_idx_r] = s_cmd_ready;
            end
            ST_XFER: begin
                if (wr_r) begin
                    s_wr_valid              = gnt_wr_valid_s;
                    s_wr_data               = m_wr_data[grant_idx_r];
                    m_wr_ready[grant_idx_r] = s_wr_ready;
                end else begin
                    m_rd_valid[grant_idx_r] = s_rd_valid;
                end
            end
            default: begin
                s_cmd_valid = 1'b0;
            end
        endcase
    end

    // Command payload comes straight from the latch, so it is stable while stalled.
    assign s_cmd_addr = addr_r;
    assign s_cmd_len  = len_r;
    assign s_cmd_wr   = wr_r;

    // Read data is a broadcast; held at zero while in reset.
    assign m_rd_data = rst ? {DATA_WIDTH{1'b0}} : s_rd_data;

    svc_sram_burst_arb_chk #(
        .NUM_M      (NUM_M),
        .ADDR_WIDTH (ADDR_WIDTH),
        .LEN_WIDTH  (LEN_WIDTH)
    ) u_chk (
        .clk         (clk),
        .rst         (rst),
        .m_cmd_ready (m_cmd_ready),
        .m_wr_ready  (m_wr_ready),
        .m_rd_valid  (m_rd_valid),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_ready (s_cmd_ready),
        .s_cmd_addr  (s_cmd_addr),
        .s_cmd_len   (s_cmd_len),
        .s_cmd_wr    (s_cmd_wr),
        .s_wr_valid  (s_wr_valid)
    );

endmodule

// File: tb/tb_svc_sram_burst_arb.sv
// -----------------------------------------------------------------------------
// tb_svc_sram_burst_arb
//   Directed bench: a table of single-requester bursts with hand-computed
//   beat counts, plus hand-written round-robin and mid-burst reset sequences.
// -----------------------------------------------------------------------------

module tb_svc_sram_burst_arb;

    localparam int NM = 2;
    localparam int AW = 20;
    localparam int DW = 16;
    localparam int LW = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NM-1:0]          m_cmd_valid;
    logic [NM-1:0]          m_cmd_ready;
    logic [NM-1:0][AW-1:0]  m_cmd_addr;
    logic [NM-1:0][LW-1:0]  m_cmd_len;
    logic [NM-1:0]          m_cmd_wr;
    logic [NM-1:0]          m_wr_valid;
    logic [NM-1:0][DW-1:0]  m_wr_data;
    logic [NM-1:0]          m_wr_ready;
    logic [NM-1:0]          m_rd_valid;
    logic [DW-1:0]          m_rd_data;
    logic                   s_cmd_valid;
    logic                   s_cmd_ready;
    logic [AW-1:0]          s_cmd_addr;
    logic [LW-1:0]          s_cmd_len;
    logic                   s_cmd_wr;
    logic                   s_wr_valid;
    logic [DW-1:0]          s_wr_data;
    logic                   s_wr_ready;
    logic                   s_rd_valid;
    logic [DW-1:0]          s_rd_data;

    always #5 clk = ~clk;

    svc_sram_burst_arb #(
        .NUM_M(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cmd_valid(m_cmd_valid), .m_cmd_ready(m_cmd_ready),
        .m_cmd_addr(m_cmd_addr), .m_cmd_len(m_cmd_len), .m_cmd_wr(m_cmd_wr),
        .m_wr_valid(m_wr_valid), .m_wr_data(m_wr_data), .m_wr_ready(m_wr_ready),
        .m_rd_valid(m_rd_valid), .m_rd_data(m_rd_data),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready),
        .s_cmd_addr(s_cmd_addr), .s_cmd_len(s_cmd_len), .s_cmd_wr(s_cmd_wr),
        .s_wr_valid(s_wr_valid), .s_wr_data(s_wr_data), .s_wr_ready(s_wr_ready),
        .s_rd_valid(s_rd_valid), .s_rd_data(s_rd_data)
    );

    typedef struct {
        int            m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [DW-1:0] data0;
        int            cmd_stall;
        int            mode;       // 0: no gaps, 1: random gaps / toggling ready
        int            exp_beats;
    } vec_t;

    vec_t vecs[6];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m_cmd_valid = '0;
        m_cmd_addr  = '0;
        m_cmd_len   = '0;
        m_cmd_wr    = '0;
        m_wr_valid  = '0;
        m_wr_data   = '0;
        s_cmd_ready = 1'b0;
        s_wr_ready  = 1'b0;
        s_rd_valid  = 1'b0;
        s_rd_data   = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_s_cmd_valid"}, s_cmd_valid, 0);
        check({tag, "_s_wr_valid"},  s_wr_valid,  0);
        check({tag, "_m_cmd_ready"}, m_cmd_ready, 0);
        check({tag, "_m_wr_ready"},  m_wr_ready,  0);
        check({tag, "_m_rd_valid"},  m_rd_valid,  0);
        check({tag, "_s_cmd_addr"},  s_cmd_addr,  0);
        check({tag, "_s_cmd_len"},   s_cmd_len,   0);
        check({tag, "_s_cmd_wr"},    s_cmd_wr,    0);
        check({tag, "_s_wr_data"},   s_wr_data,   0);
        check({tag, "_m_rd_data"},   m_rd_data,   0);
    endtask

    // One complete burst from a single requester, acting as both requester and controller.
    task automatic run_vec(input vec_t v);
        int            other;
        int            beats;
        int            cyc;
        int            bad0;
        logic          sv;
        logic [DW-1:0] exp_d;
        logic [NM-1:0] onehot;
        other  = 1 - v.m;
        onehot = '0;
        onehot[v.m] = 1'b1;
        bad0   = bad;

        tick();
        m_cmd_valid[v.m] = 1'b1;
        m_cmd_addr[v.m]  = v.addr;
        m_cmd_len[v.m]   = v.len;
        m_cmd_wr[v.m]    = v.wr;
        s_cmd_ready      = 1'b0;
        #2;
        check("arb_latency", s_cmd_valid, 0);

        for (int k = 0; k <= v.cmd_stall; k++) begin
            tick();
            m_cmd_addr[v.m] = ~v.addr;   // already latched; must not leak through
            m_cmd_len[v.m]  = ~v.len;
            s_cmd_ready     = (k == v.cmd_stall);
            #2;
            check("cmd_valid", s_cmd_valid, 1);
            check("cmd_addr",  s_cmd_addr,  v.addr);
            check("cmd_len",   s_cmd_len,   v.len);
            check("cmd_wr",    s_cmd_wr,    v.wr);
            check("cmd_ready", m_cmd_ready, (k == v.cmd_stall) ? onehot : 2'b00);
        end

        beats = 0;
        cyc   = 0;
        if (v.wr) begin
            while (beats < v.exp_beats && cyc < 2000 && bad == bad0) begin
                tick();
                s_cmd_ready        = 1'b0;
                m_cmd_valid        = '0;
                m_wr_valid[v.m]    = (v.mode == 0) ? 1'b1 : (($urandom % 4) != 0);
                m_wr_data[v.m]     = v.data0 + DW'(beats);
                m_wr_valid[other]  = 1'b1;
                m_wr_data[other]   = 16'hDEAD;
                s_wr_ready         = (v.mode == 0) ? 1'b1 : ((cyc % 2) == 0);
                #2;
                check("wr_valid_fwd", s_wr_valid, m_wr_valid[v.m]);
                check("wr_ready_gnt", m_wr_ready, s_wr_ready ? onehot : 2'b00);
                if (m_wr_valid[v.m] && s_wr_ready) begin
                    check("wr_data", s_wr_data, v.data0 + DW'(beats));
                    beats++;
                end
                cyc++;
            end
            check("wr_beats", beats, v.exp_beats);
            tick();
            m_wr_valid = 2'b11;
            s_wr_ready = 1'b1;
            #2;
            check("wr_after_last_valid", s_wr_valid, 0);
            check("wr_after_last_ready", m_wr_ready, 0);
        end else begin
            while (beats < v.exp_beats && cyc < 2000 && bad == bad0) begin
                tick();
                s_cmd_ready     = 1'b0;
                m_cmd_valid     = '0;
                sv              = (v.mode == 0) ? 1'b1 : (($urandom % 3) != 0);
                exp_d           = sv ? (v.data0 + DW'(beats)) : DW'($urandom);
                s_rd_valid      = sv;
                s_rd_data       = exp_d;
                m_wr_valid[v.m] = 1'b1;
                s_wr_ready      = 1'b1;
                #2;
                check("rd_valid", m_rd_valid, sv ? onehot : 2'b00);
                check("rd_data",  m_rd_data,  exp_d);
                check("rd_no_wr", s_wr_valid, 0);
                if (sv) beats++;
                cyc++;
            end
            check("rd_beats", beats, v.exp_beats);
            tick();
            s_rd_valid = 1'b1;
            s_rd_data  = 16'h5A5A;
            m_wr_valid = '0;
            #2;
            check("rd_after_last", m_rd_valid, 0);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        int exp_order[5];
        int n;
        int last_g;
        logic [NM-1:0] exp_wr;

        rst = 1'b1;
        idle_inputs();
        //          m  wr    addr       len     data0     stall mode beats
        vecs[0] = '{0, 1'b1, 20'h00100, 8'd3,   16'h00A0, 0,    0,   4};
        vecs[1] = '{1, 1'b0, 20'h02000, 8'd7,   16'h5000, 0,    1,   8};
        vecs[2] = '{0, 1'b1, 20'h30000, 8'd5,   16'h1230, 5,    1,   6};
        vecs[3] = '{1, 1'b1, 20'h00040, 8'd0,   16'hBEEF, 0,    0,   1};
        vecs[4] = '{0, 1'b0, 20'hFFFFF, 8'd255, 16'h0100, 0,    0,   256};
        vecs[5] = '{1, 1'b0, 20'h00010, 8'd0,   16'h7777, 2,    1,   1};

        // Reset state
        tick();
        tick();
        #2;
        check_zero("reset");
        tick();
        rst = 1'b0;

        // Round robin: both requesters always asking, len=0 writes
        exp_order = '{0, 1, 0, 1, 0};
        n = 0;
        last_g = 0;
        m_cmd_valid   = 2'b11;
        m_cmd_addr[0] = 20'h11111;
        m_cmd_addr[1] = 20'h22222;
        m_cmd_len     = '0;
        m_cmd_wr      = 2'b11;
        m_wr_valid    = 2'b11;
        m_wr_data[0]  = 16'hAAAA;
        m_wr_data[1]  = 16'hBBBB;
        s_cmd_ready   = 1'b1;
        s_wr_ready    = 1'b1;
        for (int c = 0; c < 14; c++) begin
            #2;
            if (m_cmd_ready != 2'b00) begin
                check("rr_onehot", $countones(m_cmd_ready), 1);
                if (n < 5) begin
                    check("rr_order", m_cmd_ready[1], exp_order[n]);
                    check("rr_addr", s_cmd_addr, (exp_order[n] == 1) ? 20'h22222 : 20'h11111);
                    last_g = exp_order[n];
                end
                n++;
            end
            if (m_wr_ready != 2'b00) begin
                exp_wr = '0;
                exp_wr[last_g] = 1'b1;
                check("rr_wready", m_wr_ready, exp_wr);
                check("rr_wdata", s_wr_data, (last_g == 1) ? 16'hBBBB : 16'hAAAA);
            end
            tick();
        end
        check("rr_grants", n, 5);
        m_cmd_valid = '0;
        #2;
        check("rr_tail", m_wr_ready, 2'b01);
        tick();
        idle_inputs();

        // Table of single-requester bursts
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i]);
        end

        // Reset during beat 2 of an 8-beat write by m0
        tick();
        m_cmd_valid[0] = 1'b1;
        m_cmd_addr[0]  = 20'h55555;
        m_cmd_len[0]   = 8'd7;
        m_cmd_wr[0]    = 1'b1;
        s_cmd_ready    = 1'b1;
        tick();
        tick();
        m_cmd_valid   = '0;
        s_cmd_ready   = 1'b0;
        m_wr_valid[0] = 1'b1;
        m_wr_data[0]  = 16'hC000;
        s_wr_ready    = 1'b1;
        tick();
        m_wr_data[0]  = 16'hC001;
        tick();
        m_wr_data[0]  = 16'hC002;
        rst           = 1'b1;
        s_rd_valid    = 1'b1;
        s_rd_data     = 16'h1234;
        m_cmd_valid   = 2'b11;
        m_cmd_addr[0] = 20'h00AAA;
        m_cmd_addr[1] = 20'h00BBB;
        m_cmd_len     = '0;
        m_cmd_wr      = 2'b11;
        #2;
        check("rst_beat2_data", s_wr_data, 16'hC002);
        tick();
        #2;
        check_zero("midrst");
        tick();
        rst         = 1'b0;
        s_rd_valid  = 1'b0;
        m_wr_valid  = '0;
        s_cmd_ready = 1'b1;
        #2;
        check("post_rst_idle", s_cmd_valid, 0);
        tick();
        #2;
        check("post_rst_grant", m_cmd_ready, 2'b01);
        check("post_rst_addr", s_cmd_addr, 20'h00AAA);
        tick();
        m_cmd_valid  = '0;
        m_wr_valid   = 2'b11;
        m_wr_data[0] = 16'hD00D;
        m_wr_data[1] = 16'hFFFF;
        #2;
        check("post_rst_wready", m_wr_ready, 2'b01);
        check("post_rst_wdata", s_wr_data, 16'hD00D);
        tick();
        idle_inputs();
        run_vec(vecs[0]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
